// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg                                                                    |
// | ALU command encoding, sequencer state encoding and default settle time.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] c_op_add  = 3'd0;
  localparam logic [2:0] c_op_sub  = 3'd1;
  localparam logic [2:0] c_op_xor  = 3'd2;
  localparam logic [2:0] c_op_slt  = 3'd3;
  localparam logic [2:0] c_op_and  = 3'd4;
  localparam logic [2:0] c_op_nand = 3'd5;
  localparam logic [2:0] c_op_nor  = 3'd6;
  localparam logic [2:0] c_op_or   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int c_settle_cycles_default = 16;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | settle_timer                                                               |
// | Loadable down-counter; o_done flags a count of zero.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module settle_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_sequencer                                                              |
// | Issues operands to a combinational ALU, waits a settle interval, captures  |
// | the result and flags, and hands them downstream over valid/ready.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = c_settle_cycles_default,
  parameter int CNT_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_over,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_over,
  output logic             out_zero,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_done;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_carry;
  logic             r_out_over;
  logic             r_out_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE with out_ready high completes the transfer and may accept on the same edge.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_done) w_next = S_DONE;
      end
      S_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_next = in_valid ? S_SETTLE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept  = in_valid && w_in_ready;
  assign w_capture = (r_state == S_SETTLE) && w_done;

  settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_accept),
    .i_en       (r_state == S_SETTLE),
    .i_load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_accept) begin
      r_alu_a   <= in_a;
      r_alu_b   <= in_b;
      r_alu_sel <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_over   <= 1'b0;
      r_out_zero   <= 1'b0;
    end else if (w_capture) begin
      r_out_result <= alu_out;
      r_out_carry  <= alu_carry;
      r_out_over   <= alu_over;
      r_out_zero   <= alu_zero;
    end
  end

  assign in_ready   = w_in_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_over   = r_out_over;
  assign out_zero   = r_out_zero;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_sequencer                                                           |
// | Directed bench for alu_sequencer with a behavioural ALU behind each DUT.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, alu_a, alu_b, alu_out, out_result;
  logic [2:0]  in_op, alu_sel;
  logic        alu_carry, alu_over, alu_zero, out_carry, out_over, out_zero;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0] in_a1, in_b1, alu_a1, alu_b1, alu_out1, out_result1;
  logic [2:0]  in_op1, alu_sel1;
  logic        alu_carry1, alu_over1, alu_zero1, out_carry1, out_over1, out_zero1;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {carry, over, zero, result}
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    c = 1'b0;
    o = 1'b0;
    r = '0;
    case (op)
      c_op_add: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      c_op_sub: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      c_op_xor:  r = a ^ b;
      c_op_slt:  r = {31'd0, ($signed(a) < $signed(b))};
      c_op_and:  r = a & b;
      c_op_nand: r = ~(a & b);
      c_op_nor:  r = ~(a | b);
      default:   r = a | b;
    endcase
    return {c, o, (r == 32'd0), r};
  endfunction

  always_comb {alu_carry, alu_over, alu_zero, alu_out} = alu_model(alu_a, alu_b, alu_sel);
  always_comb {alu_carry1, alu_over1, alu_zero1, alu_out1} = alu_model(alu_a1, alu_b1, alu_sel1);

  alu_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_over(alu_over), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_over(out_over), .out_zero(out_zero), .busy(busy)
  );

  alu_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_W(5)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_op(in_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
    .alu_out(alu_out1), .alu_carry(alu_carry1), .alu_over(alu_over1), .alu_zero(alu_zero1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
    .out_carry(out_carry1), .out_over(out_over1), .out_zero(out_zero1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and hold it until the accept edge has passed.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({out_result, out_carry, out_over, out_zero} !== 35'd0) begin
      errors++; $display("FAIL reset_out: out=%h flags=%b required 0", out_result, {out_carry, out_over, out_zero});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 67'd0) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h sel=%0d required 0", alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_add();
    int n;
    out_ready = 1'b1;
    issue(32'd10, 32'd1, c_op_add);
    wait_valid(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL add_latency: edges=%0d required 4", n); end
    checks++;
    if ({out_result, out_carry, out_over, out_zero} !== {32'd11, 3'b000}) begin
      errors++; $display("FAIL add_result: out=%h flags=%b required 0000000b 000", out_result, {out_carry, out_over, out_zero});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd11) begin
      errors++; $display("FAIL add_hold: valid=%0b out=%h required 0 0000000b", out_valid, out_result);
    end
  endtask

  task automatic test_sub();
    int n;
    out_ready = 1'b1;
    issue(32'd0, 32'd1, c_op_sub);
    wait_valid(n);
    checks++;
    if ({out_result, out_carry, out_over, out_zero} !== {32'hFFFF_FFFF, 3'b000}) begin
      errors++; $display("FAIL sub_neg: out=%h flags=%b required ffffffff 000", out_result, {out_carry, out_over, out_zero});
    end
    tick();
    issue(32'd5, 32'd5, c_op_sub);
    wait_valid(n);
    checks++;
    if ({out_result, out_carry, out_over, out_zero} !== {32'd0, 3'b101}) begin
      errors++; $display("FAIL sub_zero: out=%h flags=%b required 00000000 101", out_result, {out_carry, out_over, out_zero});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    issue(32'hFFFF_0000, 32'hFFFF_0000, c_op_and);
    wait_valid(n);
    in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; in_op = c_op_or;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_result !== 32'hFFFF_0000) begin
        errors++; $display("FAIL bp_hold%0d: valid/ready=%b out=%h required 10 ffff0000", i, {out_valid, in_ready}, out_result);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%0b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b01 || alu_a !== 32'd1 || alu_b !== 32'd2) begin
      errors++; $display("FAIL bp_accept: valid/busy=%b a=%h b=%h required 01 1 2", {out_valid, busy}, alu_a, alu_b);
    end
    wait_valid(n);
    checks++;
    if (n !== 4 || out_result !== 32'd3) begin
      errors++; $display("FAIL bp_next: edges=%0d out=%h required 4 3", n, out_result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    int n;
    va[0] = 32'h5555_5555; vb[0] = 32'hAAAA_AAAA; vr[0] = 32'hFFFF_FFFF;
    va[1] = 32'h0F0F_0000; vb[1] = 32'h0000_00F0; vr[1] = 32'h0F0F_00F0;
    va[2] = 32'h1234_0000; vb[2] = 32'h0000_5678; vr[2] = 32'h1234_5678;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_op = c_op_or;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin in_a = va[i+1]; in_b = vb[i+1]; end
      else in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
        checks++;
        if (alu_a !== va[i] || alu_b !== vb[i]) begin
          errors++; $display("FAIL b2b_stable%0d: a=%h b=%h required %h %h", i, alu_a, alu_b, va[i], vb[i]);
        end
        tick(); n++;
      end
      checks++;
      if (n !== 4 || out_result !== vr[i]) begin
        errors++; $display("FAIL b2b_result%0d: edges=%0d out=%h required 4 %h", i, n, out_result, vr[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    issue(32'd7, 32'd8, c_op_sub);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL rst_mid_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({out_result, out_carry, out_over, out_zero} !== 35'd0 || {alu_a, alu_b, alu_sel} !== 67'd0) begin
      errors++; $display("FAIL rst_mid_clear: out=%h a=%h b=%h sel=%0d required 0", out_result, alu_a, alu_b, alu_sel);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop%0d: out_valid=%0b required 0", i, out_valid); end
    end
  endtask

  task automatic test_settle_one();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_a1 = 32'd1; in_b1 = 32'd1; in_op1 = c_op_xor;
    checks++;
    if (in_ready1 !== 1'b1) begin errors++; $display("FAIL s1_ready: in_ready=%0b required 1", in_ready1); end
    tick();
    in_valid1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0) begin errors++; $display("FAIL s1_early: out_valid=%0b required 0", out_valid1); end
    tick();
    checks++;
    if (out_valid1 !== 1'b1 || out_result1 !== 32'd0 || out_zero1 !== 1'b1) begin
      errors++; $display("FAIL s1_result: valid=%0b out=%h zero=%0b required 1 0 1", out_valid1, out_result1, out_zero1);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_settle_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Clocked issue/capture stage wrapped around the combinational, gate-delay-modelled 32-bit ALU. It accepts one operation (operands + 3-bit command) through a valid/ready handshake and drives the operands onto the ALU inputs, holding them stable. After a programmable settle interval it registers the ALU result and carry, overflow and zero flags, then presents them downstream through a second valid/ready handshake. It sits directly upstream of the ALU, feeding its inputs, and directly downstream of it, consuming its outputs.

Parameters:
WIDTH, 32, operand/result width; must match the ALU (32).
SETTLE_CYCLES, 16, clock edges between accept and capture; legal range 1..31. SETTLE_CYCLES × clock period must exceed the ALU worst-case ripple delay.
CNT_W, 5, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
clk  in  1  single clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream has an operation
in_ready  out  1  stage can accept
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
alu_a  out  WIDTH  to ALU operand a
alu_b  out  WIDTH  to ALU operand b
alu_sel  out  3  to ALU selector
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry flag
alu_over  in  1  ALU overflow flag
alu_zero  in  1  ALU zero flag
out_valid  out  1  captured result available
out_ready  in  1  downstream accepts
out_result  out  WIDTH  registered result
out_carry  out  1  registered carry
out_over  out  1  registered overflow
out_zero  out  1  registered zero
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock, synchronous and active-high. Takes priority over every other event and applies in any state, including mid-SETTLE and DONE; an in-flight operation is dropped silently.
- Reset values: state=IDLE, counter=0, alu_a=0, alu_b=0, alu_sel=0, out_valid=0, out_result=0, out_carry=0, out_over=0, out_zero=0.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1: latch in_a, in_b, in_op into alu_a, alu_b, alu_sel; load counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: in_ready=0. When counter != 0, decrement it. When counter == 0, capture alu_out, alu_carry, alu_over, alu_zero into the out_* registers, set out_valid=1, and go to DONE.
  - DONE: out_valid=1. in_ready = out_ready.
    - out_ready=1 and in_valid=0: clear out_valid; go to IDLE.
    - out_ready=1 and in_valid=1 (simultaneous): complete the current transfer and accept the new operation on the same edge (latch operands, reload counter, go to SETTLE, clear out_valid). No bubble.
    - out_ready=0: hold. out_* and out_valid stay stable.
- Latency: with the accept edge as E0, out_valid rises after edge E0+SETTLE_CYCLES. SETTLE_CYCLES=1 captures on the first edge after accept.
- Throughput: one operation per SETTLE_CYCLES+1 cycles with out_ready held high and in_valid continuously high.
- alu_a, alu_b and alu_sel change only on an accept edge. Between accepts they hold their last value, so the ALU output stays stable while in DONE.
- out_* registers change only on a capture edge (or reset). They keep their last value after the handshake completes.
- Upstream in_a/in_b/in_op are sampled only on the accept edge and may change freely at other times.
- in_valid asserted while in_ready=0 is ignored; upstream must hold its operation until it sees in_ready=1.
- The stage performs no arithmetic; values are passed through bit-exact, at full WIDTH.

Decomposition:
- Shared package alu_pkg:
  - ALU command constants (ADD=0 … OR=7), identical to the ALU's encoding.
  - State encoding: IDLE=2'd0, SETTLE=2'd1, DONE=2'd2.
  - Default SETTLE_CYCLES.
- One sub-module, settle_timer: a loadable down-counter with load, enable and a done (count==0) output, parameterised by CNT_W.

Test Plan:
- ADD: in_a=10, in_b=1, op=0, SETTLE_CYCLES=4, out_ready=1 -> out_valid rises exactly 4 edges after accept; out_result=11, carry=0, over=0, zero=0.
- SUB: in_a=0, in_b=1, op=1 -> out_result=0xFFFFFFFF, carry=0, over=0, zero=0. Then in_a=5, in_b=5, op=1 -> out_result=0, zero=1, carry=1.
- Backpressure: complete an AND of 0xFFFF0000 & 0xFFFF0000, hold out_ready=0 for 6 cycles with in_valid=1 -> out_result=0xFFFF0000 stable, out_valid=1, in_ready=0 throughout. Raising out_ready accepts the next operation on the same edge.
- Back-to-back: in_valid and out_ready held high for 3 ORs (0x55555555|0xAAAAAAAA, etc.) -> 3 results in order, each SETTLE_CYCLES+1 cycles apart; alu_a/alu_b change only on accept edges.
- Reset mid-SETTLE: assert reset 2 cycles after accept -> next edge: state=IDLE, in_ready=1, out_valid=0, all out_* and alu_* = 0. That operation's result never appears.
- SETTLE_CYCLES=1 with XOR 1^1 -> out_valid on the first edge after accept; out_result=0, zero=1.
